// File: rtl/restoring_divider_4bit_seq.sv
// restoring_divider_4bit_seq: one restoring shift/subtract step per clock, start/busy/done handshake, optional dbz port via DIVIDER_DBZ_FLAG_EN
module restoring_divider_4bit_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
`ifdef DIVIDER_DBZ_FLAG_EN
  output logic             done,
  output logic             dbz
`else
  output logic             done
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] rem, quo, div, rem_nx, quo_nx;
  logic [WIDTH:0] shf, trial;
  logic [CW-1:0] cnt;
  logic last;
  assign shf = {rem, quo[WIDTH-1]};
  assign trial = shf - {1'b0, div};
  assign rem_nx = trial[WIDTH] ? shf[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nx = {quo[WIDTH-2:0], ~trial[WIDTH]};
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
    state_nx = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      quo <= '0;
      div <= '0;
      cnt <= '0;
      Q <= '0;
      R <= '0;
`ifdef DIVIDER_DBZ_FLAG_EN
      dbz <= 1'b0;
`endif
    end else if (state != RUN) begin
      if (start) begin
        rem <= '0;
        quo <= A;
        div <= B;
        cnt <= '0;
`ifdef DIVIDER_DBZ_FLAG_EN
        dbz <= 1'b0;
`endif
      end
    end else begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        Q <= quo_nx;
        R <= rem_nx;
`ifdef DIVIDER_DBZ_FLAG_EN
        dbz <= div == '0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_restoring_divider_4bit_seq.sv
// tb_restoring_divider_4bit_seq: table-driven vectors plus hand sequences for abort, ignored start and back-to-back runs
module tb_restoring_divider_4bit_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic [3:0] Q, R;
  logic busy, done;
`ifdef DIVIDER_DBZ_FLAG_EN
  logic dbz;
`endif
  int n_vec = 0;
  int n_bad = 0;
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
  } vec_t;
  vec_t vecs[9];
  restoring_divider_4bit_seq #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .A(A),
    .B(B),
    .Q(Q),
    .R(R),
    .busy(busy),
`ifdef DIVIDER_DBZ_FLAG_EN
    .done(done),
    .dbz(dbz)
`else
    .done(done)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic do_div(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq, input logic [3:0] er);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A = ~a;
    B = ~b;
    chk("busy_first", {30'd0, busy, done}, 2'b10);
`ifdef DIVIDER_DBZ_FLAG_EN
    chk("dbz_cleared", dbz, 0);
`endif
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk("busy_run", {30'd0, busy, done}, 2'b10);
    end
    @(negedge clk);
    chk("done_cycle", {30'd0, busy, done}, 2'b01);
    chk("q", Q, eq);
    chk("r", R, er);
`ifdef DIVIDER_DBZ_FLAG_EN
    chk("dbz", dbz, b == 4'd0);
`endif
    @(negedge clk);
    chk("done_single", done, 0);
  endtask
  initial begin
    logic seen;
    vecs[0] = '{4'd13, 4'd3, 4'd4, 4'd1};
    vecs[1] = '{4'd15, 4'd1, 4'd15, 4'd0};
    vecs[2] = '{4'd2, 4'd7, 4'd0, 4'd2};
    vecs[3] = '{4'd9, 4'd0, 4'd15, 4'd9};
    vecs[4] = '{4'd7, 4'd2, 4'd3, 4'd1};
    vecs[5] = '{4'd15, 4'd15, 4'd1, 4'd0};
    vecs[6] = '{4'd0, 4'd5, 4'd0, 4'd0};
    vecs[7] = '{4'd14, 4'd3, 4'd4, 4'd2};
    vecs[8] = '{4'd8, 4'd1, 4'd8, 4'd0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {22'd0, Q, R, busy, done}, 10'd0);
`ifdef DIVIDER_DBZ_FLAG_EN
    chk("reset_dbz", dbz, 0);
`endif
    foreach (vecs[i]) begin
      do_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
      @(negedge clk);
      chk("hold_idle", {24'd0, Q, R}, {24'd0, vecs[i].q, vecs[i].r});
    end
    A = 4'd12;
    B = 4'd5;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    A = 4'd1;
    B = 4'd1;
    @(negedge clk);
    start = 1'b0;
    chk("ignored_busy", busy, 1);
    repeat (2) @(negedge clk);
    chk("ignored_done", {26'd0, Q, R, busy, done}, {26'd0, 4'd2, 4'd2, 2'b01});
    @(negedge clk);
    A = 4'd14;
    B = 4'd4;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_busy1", busy, 1);
    repeat (4) @(negedge clk);
    chk("b2b_first", {26'd0, Q, R, busy, done}, {26'd0, 4'd3, 4'd2, 2'b01});
    A = 4'd7;
    B = 4'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_restart", {30'd0, busy, done}, 2'b10);
    chk("b2b_hold", {24'd0, Q, R}, {24'd0, 4'd3, 4'd2});
    repeat (3) @(negedge clk);
    chk("b2b_pre", done, 0);
    @(negedge clk);
    chk("b2b_second", {26'd0, Q, R, busy, done}, {26'd0, 4'd3, 4'd1, 2'b01});
    @(negedge clk);
    A = 4'd13;
    B = 4'd3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", {22'd0, Q, R, busy, done}, 10'd0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= done | busy;
    end
    chk("abort_quiet", seen, 0);
    rst = 1'b1;
    start = 1'b1;
    A = 4'd5;
    B = 4'd1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("rst_wins", busy, 0);
    do_div(4'd8, 4'd3, 4'd2, 4'd2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
